// File: rtl/td_train_sequencer.sv
// Step/phase sequencer for one DQN training episode: drives the shared step/controller bus,
// captures the policy action, pulses the one-hot TD-lane enable and guards both handshakes.
module td_train_sequencer #(
   parameter int LATCH_PHASE = 7,
   parameter int LAST_PHASE  = 8,
   parameter int ACT_PHASE   = 5,
   parameter int TIMEOUT     = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] episode_len,
   input  logic       act_valid,
   input  logic [1:0] act_in,
   input  logic       wb_ack,
   output logic [3:0] step,
   output logic [3:0] controller,
   output logic [1:0] act,
   output logic [3:0] lane_en,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {IDLE, RUN, WAIT_ACT, WAIT_ACK} state_t;

   localparam logic [3:0] LATCH_P   = 4'(LATCH_PHASE);
   localparam logic [3:0] LAST_P    = 4'(LAST_PHASE);
   localparam logic [3:0] ACT_P     = 4'(ACT_PHASE);
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t     state, state_d;
   logic [3:0] step_d, ctrl_d, len_q, len_d, lane_d;
   logic [1:0] act_d;
   logic [7:0] wait_cnt, cnt_d;
   logic       busy_d, done_d, err_d;

   assign dbg_state = state;

   // Handshakes: act_valid and wb_ack are level inputs with no ready returned. A handshake
   // completes on any edge where the input is high while the FSM sits in the matching wait
   // state; at all other times the inputs are ignored. A handshake beats a same-cycle timeout.
   always_comb begin
      state_d = state;
      step_d  = step;
      ctrl_d  = controller;
      act_d   = act;
      len_d   = len_q;
      cnt_d   = wait_cnt;
      busy_d  = busy;
      done_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_d = '0;
            if (start) begin
               if (episode_len == 4'd0) begin
                  err_d = 1'b1;
               end else begin
                  len_d   = episode_len;
                  step_d  = 4'd1;
                  ctrl_d  = 4'd1;
                  busy_d  = 1'b1;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            ctrl_d = controller + 4'd1;
            cnt_d  = '0;
            if (ctrl_d == ACT_P)       state_d = WAIT_ACT;
            else if (ctrl_d == LAST_P) state_d = WAIT_ACK;
         end
         WAIT_ACT: begin
            if (act_valid) begin
               act_d   = act_in;
               ctrl_d  = ACT_P + 4'd1;
               cnt_d   = '0;
               state_d = (ctrl_d == LAST_P) ? WAIT_ACK : RUN;
            end else if (wait_cnt == WAIT_LAST) begin
               state_d = IDLE;
               step_d  = '0;
               ctrl_d  = '0;
               busy_d  = 1'b0;
               cnt_d   = '0;
               err_d   = 1'b1;
            end else begin
               cnt_d = wait_cnt + 8'd1;
            end
         end
         WAIT_ACK: begin
            if (wb_ack) begin
               cnt_d = '0;
               if (step == len_q) begin
                  state_d = IDLE;
                  step_d  = '0;
                  ctrl_d  = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  step_d  = step + 4'd1;
                  ctrl_d  = 4'd1;
                  state_d = RUN;
               end
            end else if (wait_cnt == WAIT_LAST) begin
               state_d = IDLE;
               step_d  = '0;
               ctrl_d  = '0;
               busy_d  = 1'b0;
               cnt_d   = '0;
               err_d   = 1'b1;
            end else begin
               cnt_d = wait_cnt + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Lane enable follows the next phase so it is registered alongside controller.
      lane_d = (ctrl_d == LATCH_P) ? (4'b0001 << act_d) : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         step       <= '0;
         controller <= '0;
         act        <= '0;
         lane_en    <= '0;
         len_q      <= '0;
         wait_cnt   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_d;
         step       <= step_d;
         controller <= ctrl_d;
         act        <= act_d;
         lane_en    <= lane_d;
         len_q      <= len_d;
         wait_cnt   <= cnt_d;
         busy       <= busy_d;
         done       <= done_d;
         err        <= err_d;
      end
   end

endmodule

// File: tb/tb_td_train_sequencer.sv
// Directed bench for td_train_sequencer: reset, single/multi-step episodes, handshake stalls,
// watchdog abort, handshake-vs-timeout race, reset mid-episode and start while busy.
module tb_td_train_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] episode_len = '0;
   logic       act_valid = 1'b0;
   logic [1:0] act_in = '0;
   logic       wb_ack = 1'b0;
   logic [3:0] step, controller, lane_en;
   logic [1:0] act, dbg_state;
   logic       busy, done, err;

   int n_checks = 0;
   int n_errors = 0;
   logic [3:0] exp_q[$];

   td_train_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .episode_len(episode_len),
      .act_valid(act_valid), .act_in(act_in), .wb_ack(wb_ack),
      .step(step), .controller(controller), .act(act), .lane_en(lane_en),
      .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
   );

   // clock / reset block
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // driver tasks: inputs change and outputs are sampled 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic start_episode(input logic [3:0] len);
      episode_len = len;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_step"}, 32'(step), 0);
      check({tag, "_ctrl"}, 32'(controller), 0);
      check({tag, "_act"}, 32'(act), 0);
      check({tag, "_lane"}, 32'(lane_en), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_err"}, 32'(err), 0);
   endtask

   initial begin
      logic [1:0] acts [3];
      int done_cnt;
      int bad;
      int found;
      acts[0] = 2'd0;
      acts[1] = 2'd1;
      acts[2] = 2'd3;

      // reset and idle
      rst = 1'b1;
      tick_n(2);
      rst = 1'b0;
      tick();
      check_all_zero("reset");
      check("reset_state", 32'(dbg_state), 0);
      start_episode(4'd0);
      check("len0_err", 32'(err), 1);
      check("len0_busy", 32'(busy), 0);
      tick();
      check("len0_err_pulse", 32'(err), 0);
      check("len0_ctrl", 32'(controller), 0);

      // single step, handshakes tied high
      act_valid = 1'b1;
      act_in = 2'd2;
      wb_ack = 1'b1;
      start_episode(4'd1);
      bad = 0;
      for (int k = 1; k <= 8; k++) begin
         if (controller != 4'(k)) bad++;
         if (lane_en != ((k == 7) ? 4'b0100 : 4'b0000)) bad++;
         if (step != 4'd1 || busy != 1'b1 || done != 1'b0) bad++;
         tick();
      end
      check("single_seq", 32'(bad), 0);
      check("single_done", 32'(done), 1);
      check("single_busy", 32'(busy), 0);
      check("single_step", 32'(step), 0);
      check("single_ctrl", 32'(controller), 0);
      check("single_act", 32'(act), 2);
      tick();
      check("single_done_pulse", 32'(done), 0);

      // multi-step with an action change per step
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b1000);
      done_cnt = 0;
      bad = 0;
      act_in = acts[0];
      start_episode(4'd3);
      for (int k = 1; k <= 24; k++) begin
         if (controller != 4'(((k - 1) % 8) + 1)) bad++;
         if (step != 4'((k - 1) / 8 + 1)) bad++;
         if (controller == 4'd7) begin
            if (exp_q.size() > 0) check("multi_lane", 32'(lane_en), 32'(exp_q.pop_front()));
            else check("multi_lane_extra", 32'(lane_en), 0);
         end else if (lane_en != 4'b0000) begin
            bad++;
         end
         done_cnt += int'(done);
         if (k / 8 < 3) act_in = acts[k / 8];
         tick();
      end
      check("multi_seq", 32'(bad), 0);
      check("multi_done", 32'(done), 1);
      done_cnt += int'(done);
      tick();
      done_cnt += int'(done);
      check("multi_done_cnt", 32'(done_cnt), 1);
      check("multi_lane_left", 32'(exp_q.size()), 0);

      // handshake stalls: act_valid 10 cycles late, wb_ack 20 cycles late
      act_valid = 1'b0;
      wb_ack = 1'b0;
      act_in = 2'd1;
      start_episode(4'd1);
      tick_n(4);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (controller != 4'd5 || lane_en != 4'b0000) bad++;
         if (i == 9) act_valid = 1'b1;
         tick();
      end
      check("stall_act_hold", 32'(bad), 0);
      check("stall_ctrl6", 32'(controller), 6);
      check("stall_act", 32'(act), 1);
      act_valid = 1'b0;
      tick();
      check("stall_lane", 32'(lane_en), 32'(4'b0010));
      tick();
      act_valid = 1'b1;
      act_in = 2'd3;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (controller != 4'd8 || lane_en != 4'b0000 || act != 2'd1) bad++;
         if (i == 19) wb_ack = 1'b1;
         tick();
      end
      check("stall_ack_hold", 32'(bad), 0);
      check("stall_done", 32'(done), 1);
      check("stall_act_after", 32'(act), 1);
      wb_ack = 1'b0;
      act_valid = 1'b0;

      // watchdog: wb_ack never arrives
      act_valid = 1'b1;
      act_in = 2'd0;
      start_episode(4'd2);
      tick_n(7);
      check("wd_enter", 32'(controller), 8);
      bad = 0;
      for (int i = 0; i < 255; i++) begin
         if (controller != 4'd8 || err != 1'b0) bad++;
         tick();
      end
      check("wd_hold", 32'(bad), 0);
      check("wd_err", 32'(err), 1);
      check("wd_busy", 32'(busy), 0);
      check("wd_ctrl", 32'(controller), 0);
      check("wd_step", 32'(step), 0);
      check("wd_lane", 32'(lane_en), 0);
      check("wd_state", 32'(dbg_state), 0);
      tick();
      check("wd_err_pulse", 32'(err), 0);

      // wb_ack on exactly the timeout cycle: handshake wins
      start_episode(4'd2);
      tick_n(7);
      for (int i = 0; i < 255; i++) begin
         if (i == 254) wb_ack = 1'b1;
         tick();
      end
      check("race_err", 32'(err), 0);
      check("race_step", 32'(step), 2);
      check("race_ctrl", 32'(controller), 1);
      check("race_busy", 32'(busy), 1);
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         tick();
         if (done) found = 1;
      end
      check("race_finish", 32'(found), 1);
      wb_ack = 1'b0;
      tick();

      // start while busy is ignored; reset at step 2 phase 6
      act_valid = 1'b1;
      wb_ack = 1'b1;
      act_in = 2'd3;
      start_episode(4'd3);
      tick();
      start = 1'b1;
      episode_len = 4'd1;
      tick();
      start = 1'b0;
      check("busy_start_step", 32'(step), 1);
      check("busy_start_ctrl", 32'(controller), 3);
      tick_n(6);
      check("busy_len_step", 32'(step), 2);
      check("busy_len_done", 32'(done), 0);
      tick_n(5);
      check("midrst_pre_ctrl", 32'(controller), 6);
      rst = 1'b1;
      tick();
      check_all_zero("midrst");
      rst = 1'b0;
      tick_n(3);
      check("midrst_idle_busy", 32'(busy), 0);
      check("midrst_idle_ctrl", 32'(controller), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
